// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game controller: frame-ticked FSM, ball/paddle physics, scoring, pixel request
module pong_game_ctrl #(
  parameter int BALL_SIZE    = 8,
  parameter int PAD_H        = 64,
  parameter int BALL_SPD     = 2,
  parameter int PAD_SPD      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       blank,
  input  logic       start,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] lpad_y,
  output logic [9:0] rpad_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       pix
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0]         X_CTR   = 10'd316;
  localparam logic [9:0]         Y_CTR   = 10'd236;
  localparam logic [9:0]         PAD_RST = 10'd208;
  localparam logic signed [11:0] PAD_MAX = 12'(480 - PAD_H);
  localparam logic signed [10:0] V_POS   = 11'(BALL_SPD);
  localparam logic signed [10:0] V_NEG   = 11'(-BALL_SPD);
  localparam logic signed [10:0] Y_BOT   = 11'(480 - BALL_SIZE);
  localparam logic signed [10:0] X_LHIT  = 11'sd24;
  localparam logic signed [10:0] X_RHIT  = 11'(616 - BALL_SIZE);
  localparam logic signed [10:0] X_RMISS = 11'(640 - BALL_SIZE);
  localparam logic [3:0]         WIN     = 4'(WIN_SCORE);

  state_t           state_q, state_d;
  logic             vsync_q, vsync_d, tick_q, tick_d;
  logic [9:0]       bx_q, bx_d, by_q, by_d, lp_q, lp_d, rp_q, rp_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic             serve_left_q, serve_left_d;
  logic [3:0]       sl_q, sl_d, sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [10:0] nx, ny;
  logic               l_ov, r_ov, l_hit, r_hit, l_miss, r_miss;
  logic               in_ball, in_lpad, in_rpad;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic signed [11:0] t;
    t = $signed({2'b00, y});
    if (up && !dn)      t = t - 12'(PAD_SPD);
    else if (dn && !up) t = t + 12'(PAD_SPD);
    if (t < 12'sd0)        t = 12'sd0;
    else if (t > PAD_MAX)  t = PAD_MAX;
    return t[9:0];
  endfunction

  always_comb begin
    vsync_d      = vsync;
    tick_d       = vsync_q & ~vsync;
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    lp_d         = lp_q;
    rp_d         = rp_q;
    dx_neg_d     = dx_neg_q;
    dy_neg_d     = dy_neg_q;
    serve_left_d = serve_left_q;
    sl_d         = sl_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;

    nx = $signed({1'b0, bx_q}) + (dx_neg_q ? V_NEG : V_POS);
    ny = $signed({1'b0, by_q}) + (dy_neg_q ? V_NEG : V_POS);
    // Overlap uses the paddle positions from before this frame's paddle move
    l_ov = ({1'b0, by_q} + 11'(BALL_SIZE) > {1'b0, lp_q}) && ({1'b0, by_q} < {1'b0, lp_q} + 11'(PAD_H));
    r_ov = ({1'b0, by_q} + 11'(BALL_SIZE) > {1'b0, rp_q}) && ({1'b0, by_q} < {1'b0, rp_q} + 11'(PAD_H));
    l_hit  = dx_neg_q && (nx <= X_LHIT) && l_ov;
    r_hit  = !dx_neg_q && (nx >= X_RHIT) && r_ov;
    l_miss = !l_hit && (nx <= 11'sd0);
    r_miss = !r_hit && (nx >= X_RMISS);

    if (tick_q) begin
      if (state_q == S_SERVE || state_q == S_PLAY || state_q == S_POINT) begin
        lp_d = pad_step(lp_q, l_up, l_dn);
        rp_d = pad_step(rp_q, r_up, r_dn);
      end
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_d      = S_SERVE;
            sl_d         = 4'd0;
            sr_d         = 4'd0;
            cnt_d        = '0;
            serve_left_d = 1'b0;
            bx_d         = X_CTR;
            by_d         = Y_CTR;
          end
        end
        S_SERVE: begin
          bx_d = X_CTR;
          by_d = Y_CTR;
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d  = S_PLAY;
            cnt_d    = '0;
            dx_neg_d = serve_left_q;
            dy_neg_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (l_miss || r_miss) begin
            state_d = S_POINT;
            cnt_d   = '0;
            // Serve goes toward whoever just lost the point
            if (l_miss) begin
              sr_d         = (sr_q >= WIN) ? sr_q : sr_q + 4'd1;
              serve_left_d = 1'b1;
            end else begin
              sl_d         = (sl_q >= WIN) ? sl_q : sl_q + 4'd1;
              serve_left_d = 1'b0;
            end
          end else begin
            if (l_hit) begin
              bx_d     = 10'd24;
              dx_neg_d = 1'b0;
            end else if (r_hit) begin
              bx_d     = X_RHIT[9:0];
              dx_neg_d = 1'b1;
            end else begin
              bx_d = nx[9:0];
            end
            if (ny <= 11'sd0) begin
              by_d     = 10'd0;
              dy_neg_d = 1'b0;
            end else if (ny >= Y_BOT) begin
              by_d     = Y_BOT[9:0];
              dy_neg_d = 1'b1;
            end else begin
              by_d = ny[9:0];
            end
          end
        end
        S_POINT: begin
          if (cnt_q == CNT_W'(POINT_FRAMES - 1)) begin
            cnt_d = '0;
            if (sl_q == WIN || sr_q == WIN) begin
              state_d = S_OVER;
            end else begin
              state_d = S_SERVE;
              bx_d    = X_CTR;
              by_d    = Y_CTR;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b1;
      tick_q       <= 1'b0;
      bx_q         <= X_CTR;
      by_q         <= Y_CTR;
      lp_q         <= PAD_RST;
      rp_q         <= PAD_RST;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      serve_left_q <= 1'b0;
      sl_q         <= 4'd0;
      sr_q         <= 4'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      tick_q       <= tick_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      lp_q         <= lp_d;
      rp_q         <= rp_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      serve_left_q <= serve_left_d;
      sl_q         <= sl_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    in_ball = ({1'b0, hcount} >= {1'b0, bx_q}) && ({1'b0, hcount} < {1'b0, bx_q} + 11'(BALL_SIZE)) &&
              ({1'b0, vcount} >= {1'b0, by_q}) && ({1'b0, vcount} < {1'b0, by_q} + 11'(BALL_SIZE));
    in_lpad = (hcount >= 10'd16) && (hcount < 10'd24) &&
              ({1'b0, vcount} >= {1'b0, lp_q}) && ({1'b0, vcount} < {1'b0, lp_q} + 11'(PAD_H));
    in_rpad = (hcount >= 10'd616) && (hcount < 10'd624) &&
              ({1'b0, vcount} >= {1'b0, rp_q}) && ({1'b0, vcount} < {1'b0, rp_q} + 11'(PAD_H));
    pix     = blank && (in_ball || in_lpad || in_rpad);
  end

  assign ball_x  = bx_q;
  assign ball_y  = by_q;
  assign lpad_y  = lp_q;
  assign rpad_y  = rp_q;
  assign score_l = sl_q;
  assign score_r = sr_q;
  assign state   = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - Directed bench for pong_game_ctrl against a frame-level game model
module tb_pong_game_ctrl;
  localparam int BS = 8, PH = 64, BSPD = 2, PSPD = 4, SF = 60, PF = 30, WIN = 9;

  logic       clk = 1'b0, reset = 1'b1, vsync = 1'b1, blank = 1'b0, start = 1'b0;
  logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic [9:0] ball_x, ball_y, lpad_y, rpad_y;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic       pix;

  int n_chk = 0, n_err = 0;
  bit chk_en = 0, rnd_pix = 0;

  // Game model: positions in plain integers, state as 0..4, frame count as frames spent in state
  int m_st, m_bx, m_by, m_dx, m_dy, m_lp, m_rp, m_sl, m_sr, m_fr;
  bit m_sleft;

  pong_game_ctrl #(.BALL_SIZE(BS), .PAD_H(PH), .BALL_SPD(BSPD), .PAD_SPD(PSPD),
                   .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .hcount(hcount), .vcount(vcount), .blank(blank),
    .start(start), .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .lpad_y(lpad_y), .rpad_y(rpad_y),
    .score_l(score_l), .score_r(score_r), .state(state), .pix(pix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_dx = BSPD; m_dy = BSPD;
    m_lp = 208; m_rp = 208; m_sl = 0; m_sr = 0; m_fr = 0; m_sleft = 0;
  endtask

  function automatic int pad_move(input int y, input logic up, input logic dn);
    int t = y;
    if (up && !dn) t = y - PSPD;
    if (dn && !up) t = y + PSPD;
    if (t < 0) t = 0;
    if (t > 480 - PH) t = 480 - PH;
    return t;
  endfunction

  task automatic m_step();
    int olp = m_lp, orp = m_rp, nx, ny;
    bit lhit, rhit;
    if (m_st >= 1 && m_st <= 3) begin
      m_lp = pad_move(m_lp, l_up, l_dn);
      m_rp = pad_move(m_rp, r_up, r_dn);
    end
    case (m_st)
      0, 4: if (start) begin
        m_st = 1; m_sl = 0; m_sr = 0; m_fr = 0; m_sleft = 0; m_bx = 316; m_by = 236;
      end
      1: begin
        m_fr++;
        if (m_fr == SF) begin
          m_st = 2; m_fr = 0; m_dy = BSPD; m_dx = m_sleft ? -BSPD : BSPD;
        end
      end
      2: begin
        nx = m_bx + m_dx;
        ny = m_by + m_dy;
        lhit = (m_dx < 0) && (nx <= 24) && (m_by + BS > olp) && (m_by < olp + PH);
        rhit = (m_dx > 0) && (nx + BS >= 616) && (m_by + BS > orp) && (m_by < orp + PH);
        if (!lhit && nx <= 0) begin
          m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_sleft = 1; m_st = 3; m_fr = 0;
        end else if (!rhit && nx >= 640 - BS) begin
          m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_sleft = 0; m_st = 3; m_fr = 0;
        end else begin
          if (lhit)      begin m_bx = 24;       m_dx = BSPD;  end
          else if (rhit) begin m_bx = 616 - BS; m_dx = -BSPD; end
          else           m_bx = nx;
          if (ny <= 0)            begin m_by = 0;        m_dy = BSPD;  end
          else if (ny >= 480 - BS) begin m_by = 480 - BS; m_dy = -BSPD; end
          else                    m_by = ny;
        end
      end
      3: begin
        m_fr++;
        if (m_fr == PF) begin
          m_fr = 0;
          if (m_sl == WIN || m_sr == WIN) m_st = 4;
          else begin m_st = 1; m_bx = 316; m_by = 236; end
        end
      end
      default: ;
    endcase
  endtask

  function automatic bit exp_pix();
    int h = int'(hcount), v = int'(vcount);
    bit b = (h >= m_bx && h < m_bx + BS && v >= m_by && v < m_by + BS);
    bit l = (h >= 16 && h < 24 && v >= m_lp && v < m_lp + PH);
    bit r = (h >= 616 && h < 624 && v >= m_rp && v < m_rp + PH);
    return blank && (b || l || r);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), m_st);
      chk("ball_x", int'(ball_x), m_bx);
      chk("ball_y", int'(ball_y), m_by);
      chk("lpad_y", int'(lpad_y), m_lp);
      chk("rpad_y", int'(rpad_y), m_rp);
      chk("score_l", int'(score_l), m_sl);
      chk("score_r", int'(score_r), m_sr);
      chk("pix", int'(pix), int'(exp_pix()));
    end
  end

  // Probe points biased toward the ball and paddles so pix edges get exercised
  always @(posedge clk) begin
    if (rnd_pix) begin
      int h, v;
      #2;
      case ($urandom_range(0, 3))
        0: begin h = $urandom_range(0, 639); v = $urandom_range(0, 479); end
        1: begin h = m_bx + $urandom_range(0, 11) - 2; v = m_by + $urandom_range(0, 11) - 2; end
        2: begin h = $urandom_range(14, 25); v = m_lp + $urandom_range(0, PH + 3) - 2; end
        default: begin h = $urandom_range(614, 625); v = m_rp + $urandom_range(0, PH + 3) - 2; end
      endcase
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      hcount = 10'(h);
      vcount = 10'(v);
      blank = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic frame();
    vsync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 m_step();
    vsync = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic run_until(input string name, input int target, input int budget);
    for (int i = 0; i < budget && m_st != target; i++) frame();
    chk(name, int'(state), target);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 m_reset();
    reset = 1'b0;
    chk_en = 1;
    rnd_pix = 1;
    chk("rst_state", int'(state), 0);
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 236);
    chk("rst_pads", int'(lpad_y) + int'(rpad_y), 416);
    @(posedge clk); #1;

    start = 1'b1; frame(); start = 1'b0;
    chk("serve_entry", int'(state), 1);
    frames(SF);
    chk("play_entry", int'(state), 2);
    frame();
    chk("first_step_x", int'(ball_x), 318);
    chk("first_step_y", int'(ball_y), 238);
    frames(157);
    chk("rmiss_state", int'(state), 3);
    chk("rmiss_score_l", int'(score_l), 1);
    chk("rmiss_frozen_x", int'(ball_x), 630);
    frames(PF);
    chk("point_to_serve", int'(state), 1);

    l_up = 1'b1; l_dn = 1'b1; frames(10); l_up = 1'b0; l_dn = 1'b0;
    chk("both_btn_lpad", int'(lpad_y), 208);
    r_dn = 1'b1; frames(50);
    chk("play_entry2", int'(state), 2);
    frames(146);
    chk("rhit_x", int'(ball_x), 608);
    l_up = 1'b1; frames(4); r_dn = 1'b0;
    chk("rpad_clamp", int'(rpad_y), 416);
    frames(18); l_up = 1'b0;
    chk("lpad_up", int'(lpad_y), 120);
    frames(270);
    chk("lhit_x", int'(ball_x), 24);
    chk("lhit_y", int'(ball_y), 168);
    run_until("to_point2", 3, 500);
    chk("score_l_2", int'(score_l), 2);
    frames(PF);
    l_dn = 1'b1; frames(SF); l_dn = 1'b0;
    chk("lpad_dn", int'(lpad_y), 360);
    frames(450);
    chk("lmiss_state", int'(state), 3);
    chk("lmiss_score_r", int'(score_r), 1);
    chk("lmiss_frozen_x", int'(ball_x), 2);
    frames(PF);
    chk("serve3", int'(state), 1);
    frames(SF);
    frame();
    chk("left_serve_x", int'(ball_x), 314);
    chk("left_serve_y", int'(ball_y), 238);

    rnd_pix = 0;
    reset = 1'b1;
    @(posedge clk);
    #1 m_reset();
    chk("midplay_rst_state", int'(state), 0);
    chk("midplay_rst_x", int'(ball_x), 316);
    chk("midplay_rst_scores", int'(score_l) + int'(score_r), 0);
    chk("midplay_rst_rpad", int'(rpad_y), 208);
    blank = 1'b0; hcount = 10'd320; vcount = 10'd240;
    #1 chk("pix_blank0", int'(pix), 0);
    blank = 1'b1;
    #1 chk("pix_ball", int'(pix), 1);
    reset = 1'b0;
    rnd_pix = 1;
    @(posedge clk); #1;

    start = 1'b1; frame(); start = 1'b0;
    run_until("to_over", 4, 3000);
    chk("over_score_l", int'(score_l), WIN);
    chk("over_score_r", int'(score_r), 0);
    frames(5);
    chk("over_hold", int'(state), 4);
    start = 1'b1; frame(); start = 1'b0;
    chk("restart_state", int'(state), 1);
    chk("restart_score_l", int'(score_l), 0);
    frames(3);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 8, meaning ball width and height in pixels.
REQ-002 SHALL have parameter PAD_H, default 64, meaning paddle height in pixels; paddle width fixed at 8.
REQ-003 SHALL have parameter BALL_SPD, default 2, meaning ball step per frame on each axis.
REQ-004 SHALL have parameter PAD_SPD, default 4, meaning paddle step per frame.
REQ-005 SHALL have parameter SERVE_FRAMES, default 60, meaning frames held in SERVE before ball launch.
REQ-006 SHALL have parameter POINT_FRAMES, default 30, meaning frames held in POINT after a score.
REQ-007 SHALL have parameter WIN_SCORE, default 9, meaning score that ends the game.
REQ-008 SHALL have ports clk in 1, the single clock; reset in 1, synchronous and active-high.
REQ-009 SHALL have ports vsync in 1 (active-low, from the VGA timing block); hcount in 10 and vcount in 10 (active pixel coordinates); blank in 1 (high = active video).
REQ-010 SHALL have ports start in 1; l_up in 1, l_dn in 1, r_up in 1, r_dn in 1 (level, synchronous to clk).
REQ-011 SHALL have outputs ball_x out 10, ball_y out 10 (ball top-left); lpad_y out 10, rpad_y out 10 (paddle top).
REQ-012 SHALL have outputs score_l out 4, score_r out 4, state out 3, pix out 1 (white-pixel request to the VGA iR/iG/iB inputs).

Function
REQ-013 SHALL register vsync and generate frame_tick, a one-cycle pulse on its 1->0 transition; all game state SHALL update only on the cycle following frame_tick.
REQ-014 SHALL implement FSM with encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-015 IDLE: ball centred (316,236), paddles at 208; start=1 on a frame_tick -> SERVE, scores cleared.
REQ-016 SERVE: ball held at centre, frame counter counts SERVE_FRAMES ticks, then -> PLAY with dy=+BALL_SPD and dx toward the player who lost the last point (first serve: +BALL_SPD, rightward).
REQ-017 Paddles SHALL move in SERVE, PLAY, POINT: up-only -> y-PAD_SPD, down-only -> y+PAD_SPD, both or neither -> no move; result clamped to [0, 480-PAD_H].
REQ-018 PLAY per tick: next = pos + velocity, computed in 11-bit signed arithmetic, no wrap.
REQ-019 Top wall: next_y <= 0 -> ball_y=0, dy=+BALL_SPD; bottom: next_y >= 480-BALL_SIZE -> ball_y=480-BALL_SIZE, dy=-BALL_SPD.
REQ-020 Left paddle occupies x 16..23; if dx<0, next_x <= 24 and ball_y+BALL_SIZE > lpad_y and ball_y < lpad_y+PAD_H -> ball_x=24, dx=+BALL_SPD.
REQ-021 Right paddle occupies x 616..623; if dx>0, next_x+BALL_SIZE >= 616 with the same vertical overlap test against rpad_y -> ball_x=616-BALL_SIZE, dx=-BALL_SPD.
REQ-022 Miss: next_x <= 0 without left hit -> score_r+1; next_x >= 640-BALL_SIZE without right hit -> score_l+1; either -> POINT, ball frozen.
REQ-023 Simultaneous wall and paddle events on one tick SHALL both apply (x and y resolved independently).
REQ-024 POINT: hold POINT_FRAMES ticks; if either score == WIN_SCORE -> OVER, else -> SERVE.
REQ-025 OVER: ball and scores frozen; start=1 on a frame_tick -> SERVE with scores cleared and first-serve rightward.
REQ-026 Scores SHALL never exceed WIN_SCORE.
REQ-027 pix SHALL be combinational: blank AND (pixel inside ball box, or inside either paddle box); pix=0 whenever blank=0.

Reset
REQ-028 reset=1 at any clock edge, including mid-PLAY or mid-count, SHALL on the next edge force state=IDLE, ball_x=316, ball_y=236, lpad_y=rpad_y=208, scores=0, velocities +BALL_SPD, frame counter 0, vsync history register 1.
REQ-029 No frame_tick SHALL be generated on the cycle reset deasserts.

Verification
REQ-030 Reset, start=1, 61 vsync falls -> state PLAY; next tick ball_x=318, ball_y=238.
REQ-031 PLAY, ball_y=1, dy=-2 -> ball_y=0, dy=+2; ball_y=471, dy=+2 -> ball_y=472, dy=-2.
REQ-032 ball_x=26, dx=-2, lpad_y=200, ball_y=230 -> ball_x=24, dx=+2; same with lpad_y=0 -> eventually score_r=1, state POINT, after 30 ticks SERVE with leftward serve.
REQ-033 l_up and l_dn held together for 10 ticks -> lpad_y unchanged; r_dn held 200 ticks -> rpad_y=416.
REQ-034 score_l=8, right miss -> score_l=9, after POINT state OVER; start -> SERVE, scores 0.
REQ-035 reset asserted mid-PLAY -> next edge all outputs at REQ-028 values; pix=0 while blank=0.
